// File: rtl/mem_lsu.sv
// mem_lsu: memory-access stage with integrated load/store unit.
// Non-memory instructions pass straight through; memory instructions run a
// req/ack bus transaction (IDLE -> WAIT -> DONE) while holding the pipeline.
module mem_lsu #(
    parameter int unsigned ADDR_W     = 32,
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              whilo_i,
    input  logic [31:0]       hi_i,
    input  logic [31:0]       lo_i,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_sdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              whilo_o,
    output logic [31:0]       hi_o,
    output logic [31:0]       lo_o,
    output logic              stall_req_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic              bus_err_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              adel_o,
    output logic              ades_o,
    output logic              bus_err_o
);

    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLw  = 4'd5;
    localparam logic [3:0] OpSb  = 4'd6;
    localparam logic [3:0] OpSh  = 4'd7;
    localparam logic [3:0] OpSw  = 4'd8;
    localparam logic [3:0] OpLl  = 4'd9;
    localparam logic [3:0] OpSc  = 4'd10;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              bus_req_q, bus_we_q, err_q, flush_seen_q, llbit_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [3:0]        bus_sel_q;
    logic [31:0]       bus_wdata_q, rdata_q, cnt_q;

    logic        is_load, is_store, is_half, is_word, is_byte;
    logic        misaligned, sc_fail, start;
    logic [1:0]  lane;
    logic        half_hi;
    logic [3:0]  sel_d;
    logic [31:0] sdata_d, load_data;
    logic        timeout_hit, done_evt, err_evt;

    // Decode the memory op and classify alignment / LL-SC outcome.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        unique case (mem_op_i)
            OpLb, OpLbu: begin is_load  = 1'b1; is_byte = 1'b1; end
            OpLh, OpLhu: begin is_load  = 1'b1; is_half = 1'b1; end
            OpLw, OpLl:  begin is_load  = 1'b1; is_word = 1'b1; end
            OpSb:        begin is_store = 1'b1; is_byte = 1'b1; end
            OpSh:        begin is_store = 1'b1; is_half = 1'b1; end
            OpSw, OpSc:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
        misaligned = (is_half && mem_addr_i[0]) || (is_word && (mem_addr_i[1:0] != 2'b00));
        sc_fail    = (mem_op_i == OpSc) && !llbit_q && !misaligned;
        start      = (is_load || is_store) && !misaligned && !sc_fail;
    end

    // Byte-lane steering for store data and lane enables.
    always_comb begin
        lane    = BIG_ENDIAN ? (2'd3 - mem_addr_i[1:0]) : mem_addr_i[1:0];
        half_hi = BIG_ENDIAN ? ~mem_addr_i[1] : mem_addr_i[1];
        sel_d   = 4'b1111;
        sdata_d = mem_sdata_i;
        if (is_byte) begin
            sel_d   = 4'b0001 << lane;
            sdata_d = {4{mem_sdata_i[7:0]}};
        end else if (is_half) begin
            sel_d   = half_hi ? 4'b1100 : 4'b0011;
            sdata_d = {2{mem_sdata_i[15:0]}};
        end
        if (is_load) begin
            sdata_d = 32'h0;
        end
    end

    // Extract and extend load data from the latched bus word.
    always_comb begin
        unique case (mem_op_i)
            OpLb:    load_data = {{24{rdata_q[{lane, 3'b000} + 7]}}, rdata_q[{lane, 3'b000} +: 8]};
            OpLbu:   load_data = {24'h0, rdata_q[{lane, 3'b000} +: 8]};
            OpLh:    load_data = half_hi ? {{16{rdata_q[31]}}, rdata_q[31:16]}
                                         : {{16{rdata_q[15]}}, rdata_q[15:0]};
            OpLhu:   load_data = half_hi ? {16'h0, rdata_q[31:16]} : {16'h0, rdata_q[15:0]};
            default: load_data = rdata_q;
        endcase
    end

    // Completion events in WAIT: error beats ack, ack beats timeout.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));
        done_evt    = bus_ack_i || bus_err_i || timeout_hit;
        err_evt     = bus_err_i || (timeout_hit && !bus_ack_i);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StWait;
            StWait:  if (done_evt) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bus request registers, wait counter and latched response.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_sel_q    <= 4'h0;
            bus_wdata_q  <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
            cnt_q        <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        bus_req_q    <= 1'b1;
                        bus_we_q     <= is_store;
                        bus_addr_q   <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        bus_sel_q    <= sel_d;
                        bus_wdata_q  <= sdata_d;
                        err_q        <= 1'b0;
                        flush_seen_q <= 1'b0;
                        cnt_q        <= 32'h0;
                    end
                end
                StWait: begin
                    flush_seen_q <= flush_seen_q || flush_i;
                    if (done_evt) begin
                        bus_req_q <= 1'b0;
                        rdata_q   <= bus_rdata_i;
                        err_q     <= err_evt;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // LLbit: set by a clean LL ack, cleared by SC completion or any flush.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            llbit_q <= 1'b0;
        end else if (state_q == StWait && done_evt) begin
            if (mem_op_i == OpLl && bus_ack_i && !bus_err_i && !flush_seen_q) llbit_q <= 1'b1;
            else if (mem_op_i == OpSc)                                      llbit_q <= 1'b0;
        end
    end

    // Stage outputs; everything is forced to zero while reset is held.
    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        whilo_o     = whilo_i;
        hi_o        = hi_i;
        lo_o        = lo_i;
        stall_req_o = 1'b0;
        adel_o      = 1'b0;
        ades_o      = 1'b0;
        bus_err_o   = 1'b0;
        bus_req_o   = bus_req_q;
        bus_we_o    = bus_we_q;
        bus_addr_o  = bus_addr_q;
        bus_sel_o   = bus_sel_q;
        bus_wdata_o = bus_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (misaligned) begin
                    adel_o = is_load;
                    ades_o = is_store;
                    wreg_o = 1'b0;
                end else if (sc_fail) begin
                    wdata_o = 32'h0;
                end else if (start) begin
                    stall_req_o = 1'b1;
                    wreg_o      = 1'b0;
                end
            end
            StWait: begin
                stall_req_o = 1'b1;
                wreg_o      = 1'b0;
            end
            StDone: begin
                if (is_load)              wdata_o = load_data;
                if (mem_op_i == OpSc)     wdata_o = 32'h1;
                else if (is_store)        wreg_o  = 1'b0;
                if (err_q || flush_seen_q || flush_i) wreg_o = 1'b0;
                bus_err_o = err_q;
            end
            default: ;
        endcase
        if (rst) begin
            wd_o        = 5'h0;
            wreg_o      = 1'b0;
            wdata_o     = 32'h0;
            whilo_o     = 1'b0;
            hi_o        = 32'h0;
            lo_o        = 32'h0;
            stall_req_o = 1'b0;
            adel_o      = 1'b0;
            ades_o      = 1'b0;
            bus_err_o   = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'h0;
            bus_wdata_o = 32'h0;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu (big-endian, TIMEOUT=4): a vector table for the
// single-cycle cases plus hand sequences for bus transactions.
module tb_mem_lsu;

    localparam logic [3:0] OpNone = 4'd0, OpLb = 4'd1, OpLh = 4'd3, OpLw = 4'd5;
    localparam logic [3:0] OpSh = 4'd7, OpSw = 4'd8, OpLl = 4'd9, OpSc = 4'd10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  wd = 5'd0;
    logic        wreg = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic        whilo = 1'b0;
    logic [31:0] hi = 32'h0, lo = 32'h0;
    logic [3:0]  mem_op = 4'd0;
    logic [31:0] mem_addr = 32'h0, mem_sdata = 32'h0;
    logic        bus_ack = 1'b0, bus_err_in = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    logic [4:0]  wd_out;
    logic        wreg_out, whilo_out, stall_req, bus_req, bus_we, adel, ades, bus_err_out;
    logic [31:0] wdata_out, hi_out, lo_out, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic        cap_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_sel;
    int          stalls;

    mem_lsu #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .wd_i        (wd),
        .wreg_i      (wreg),
        .wdata_i     (wdata),
        .whilo_i     (whilo),
        .hi_i        (hi),
        .lo_i        (lo),
        .mem_op_i    (mem_op),
        .mem_addr_i  (mem_addr),
        .mem_sdata_i (mem_sdata),
        .wd_o        (wd_out),
        .wreg_o      (wreg_out),
        .wdata_o     (wdata_out),
        .whilo_o     (whilo_out),
        .hi_o        (hi_out),
        .lo_o        (lo_out),
        .stall_req_o (stall_req),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_sel_o   (bus_sel),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_err_i   (bus_err_in),
        .bus_rdata_i (bus_rdata),
        .adel_o      (adel),
        .ades_o      (ades),
        .bus_err_o   (bus_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Run one bus transaction; ends sampled in DONE. The ack/err is given in WAIT cycle n_wait.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input int n_wait, input bit ack, input bit err, input bit flush_w,
                         input logic [31:0] rdata, output int n_stall);
        @(negedge clk);
        mem_op = op; mem_addr = addr; mem_sdata = sdata; bus_ack = 1'b0; bus_err_in = 1'b0;
        #1;
        n_stall = int'(stall_req);
        for (int i = 1; i <= n_wait; i++) begin
            @(negedge clk);
            flush = flush_w && (i == 1);
            if (i == n_wait) begin
                bus_ack = ack; bus_err_in = err; bus_rdata = rdata;
            end
            #1;
            if (i == 1) begin
                cap_req = bus_req; cap_we = bus_we; cap_addr = bus_addr;
                cap_sel = bus_sel; cap_wdata = bus_wdata;
            end
            n_stall += int'(stall_req);
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_err_in = 1'b0; flush = 1'b0;
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        mem_op = OpNone;
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        exp_wreg;
        logic [31:0] exp_wdata;
        bit          chk_wdata;
        logic        exp_adel;
        logic        exp_ades;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{OpNone, 32'h0,   5'd3,  1'b1, 32'h1234, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{OpLw,   32'h3,   5'd4,  1'b1, 32'h1111, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[2] = '{OpLh,   32'h101, 5'd5,  1'b1, 32'h2222, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[3] = '{OpSh,   32'h201, 5'd6,  1'b1, 32'h3333, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1};
        vecs[4] = '{OpSw,   32'h2,   5'd7,  1'b1, 32'h4444, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1};
        vecs[5] = '{OpSc,   32'h40,  5'd8,  1'b1, 32'h55,   1'b1, 32'h0,    1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'd12,  32'h40,  5'd9,  1'b1, 32'hDEAD, 1'b1, 32'hDEAD, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{OpLl,   32'h41,  5'd10, 1'b1, 32'h6666, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0};
        vecs[8] = '{OpSc,   32'h42,  5'd11, 1'b1, 32'h7777, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1};

        // Reset: all outputs zero even with live inputs.
        wd = 5'd3; wreg = 1'b1; wdata = 32'h1234; whilo = 1'b1; hi = 32'h5; lo = 32'h6;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wd", wd_out, 0);
        check("rst_wdata", wdata_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_whilo", whilo_out, 0);
        check("rst_bus_req", bus_req, 0);
        @(negedge clk);
        rst = 1'b0; whilo = 1'b0; hi = 32'h0; lo = 32'h0;
        #1;
        check("hilo_pass", lo_out, 0);

        // Single-cycle cases: pass-through, misaligned, failed SC.
        foreach (vecs[i]) begin
            @(negedge clk);
            mem_op = vecs[i].op; mem_addr = vecs[i].addr;
            wd = vecs[i].wd; wreg = vecs[i].wreg; wdata = vecs[i].wdata;
            #1;
            check($sformatf("v%0d_wd", i), wd_out, vecs[i].wd);
            check($sformatf("v%0d_wreg", i), wreg_out, vecs[i].exp_wreg);
            if (vecs[i].chk_wdata) check($sformatf("v%0d_wdata", i), wdata_out, vecs[i].exp_wdata);
            check($sformatf("v%0d_adel", i), adel, vecs[i].exp_adel);
            check($sformatf("v%0d_ades", i), ades, vecs[i].exp_ades);
            check($sformatf("v%0d_stall", i), stall_req, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_no_req", i), bus_req, 0);
        end

        // LB big-endian, ack in second WAIT cycle.
        wd = 5'd7; wreg = 1'b1; wdata = 32'h0;
        do_op(OpLb, 32'h101, 32'h0, 2, 1'b1, 1'b0, 1'b0, 32'h11807733, stalls);
        check("lb_req", cap_req, 1);
        check("lb_we", cap_we, 0);
        check("lb_addr", cap_addr, 32'h100);
        check("lb_sel", cap_sel, 4'b0100);
        check("lb_stalls", stalls, 3);
        check("lb_done_stall", stall_req, 0);
        check("lb_wdata", wdata_out, 32'hFFFFFF80);
        check("lb_wreg", wreg_out, 1);
        check("lb_done_req", bus_req, 0);
        go_idle();

        // SH zero-wait store.
        do_op(OpSh, 32'h202, 32'hAAAA5678, 1, 1'b1, 1'b0, 1'b0, 32'h0, stalls);
        check("sh_wdata", cap_wdata, 32'h56785678);
        check("sh_sel", cap_sel, 4'b0011);
        check("sh_we", cap_we, 1);
        check("sh_addr", cap_addr, 32'h200);
        check("sh_stalls", stalls, 2);
        check("sh_wreg", wreg_out, 0);
        go_idle();

        // LL then SC succeeds.
        do_op(OpLl, 32'h40, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'hCAFEBABE, stalls);
        check("ll_wdata", wdata_out, 32'hCAFEBABE);
        check("ll_wreg", wreg_out, 1);
        go_idle();
        do_op(OpSc, 32'h40, 32'h99, 1, 1'b1, 1'b0, 1'b0, 32'h0, stalls);
        check("sc1_req", cap_req, 1);
        check("sc1_we", cap_we, 1);
        check("sc1_sel", cap_sel, 4'b1111);
        check("sc1_bwdata", cap_wdata, 32'h99);
        check("sc1_wdata", wdata_out, 1);
        check("sc1_wreg", wreg_out, 1);
        go_idle();

        // Second SC fails without a bus access.
        @(negedge clk);
        mem_op = OpSc; mem_addr = 32'h40; wdata = 32'h55;
        #1;
        check("sc2_stall", stall_req, 0);
        check("sc2_wdata", wdata_out, 0);
        check("sc2_wreg", wreg_out, 1);
        @(posedge clk);
        #1;
        check("sc2_no_req", bus_req, 0);
        go_idle();

        // LL, flush, SC fails.
        do_op(OpLl, 32'h40, 32'h0, 1, 1'b1, 1'b0, 1'b0, 32'h1, stalls);
        @(negedge clk);
        mem_op = OpNone; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; mem_op = OpSc; mem_addr = 32'h40; wdata = 32'h55;
        #1;
        check("sc3_wdata", wdata_out, 0);
        check("sc3_stall", stall_req, 0);
        go_idle();

        // Timeout after 4 WAIT cycles.
        do_op(OpLw, 32'h80, 32'h0, 4, 1'b0, 1'b0, 1'b0, 32'h0, stalls);
        check("to_stalls", stalls, 5);
        check("to_bus_err", bus_err_out, 1);
        check("to_wreg", wreg_out, 0);
        go_idle();

        // Ack and error together: error wins.
        do_op(OpLw, 32'h80, 32'h0, 1, 1'b1, 1'b1, 1'b0, 32'h12345678, stalls);
        check("ackerr_bus_err", bus_err_out, 1);
        check("ackerr_wreg", wreg_out, 0);
        go_idle();

        // Flush during WAIT squashes the load result.
        do_op(OpLw, 32'h84, 32'h0, 2, 1'b1, 1'b0, 1'b1, 32'h87654321, stalls);
        check("flush_wreg", wreg_out, 0);
        check("flush_bus_err", bus_err_out, 0);
        go_idle();

        // Reset in WAIT.
        @(negedge clk);
        mem_op = OpLw; mem_addr = 32'h88; wd = 5'd5; wreg = 1'b1; wdata = 32'h77;
        whilo = 1'b1; hi = 32'h11;
        @(negedge clk);
        #1;
        check("rw_req_before", bus_req, 1);
        rst = 1'b1;
        #1;
        check("rw_req", bus_req, 0);
        check("rw_wd", wd_out, 0);
        check("rw_hi", hi_out, 0);
        check("rw_stall", stall_req, 0);
        @(negedge clk);
        #1;
        check("rw_req_next", bus_req, 0);
        @(negedge clk);
        rst = 1'b0; mem_op = OpNone; whilo = 1'b0; hi = 32'h0;
        #1;
        check("rw_req_after", bus_req, 0);
        check("rw_wd_after", wd_out, 5);
        check("rw_stall_after", stall_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-access pipeline stage with an integrated load/store unit, sitting between the EX/MEM and MEM/WB pipeline registers. Non-memory instructions pass their register-write and HI/LO results straight through. Memory instructions run a request/acknowledge transaction on the data bus and hold the pipeline with `stall_req_o` until it completes. The block performs byte-lane steering and sign/zero extension, detects misaligned addresses, supports LL/SC through an internal LLbit, and can time out a stuck bus.

## Interface
Parameters:
- `ADDR_W`, 32: data-bus address width. Low 2 bits select the byte lane.
- `BIG_ENDIAN`, 1: 1 maps address byte 0 to bits 31:24; 0 maps it to bits 7:0.
- `TIMEOUT`, 0: WAIT cycles before a missing ack is treated as a bus error. 0 disables the timeout.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: exception flush. Squashes the in-flight result and clears LLbit.
- `wd_i`/`wreg_i`/`wdata_i` in 5/1/32: destination register, write enable, ALU result.
- `whilo_i`/`hi_i`/`lo_i` in 1/32/32: HI/LO write enable and data.
- `mem_op_i` in 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC. Values 11–15 are treated as none.
- `mem_addr_i` in ADDR_W: effective address.
- `mem_sdata_i` in 32: store data (rt).
- `wd_o`/`wreg_o`/`wdata_o`/`whilo_o`/`hi_o`/`lo_o` out: to MEM/WB.
- `stall_req_o` out 1: stall request to the pipeline controller.
- `bus_req_o`/`bus_we_o` out 1/1: bus request and write enable. Both registered.
- `bus_addr_o` out ADDR_W: word-aligned address (low 2 bits = 0). Registered.
- `bus_sel_o` out 4: byte-lane enables. Registered.
- `bus_wdata_o` out 32: store data. Registered.
- `bus_ack_i`/`bus_err_i` in 1/1: transaction done / failed.
- `bus_rdata_i` in 32: read data. Valid with `bus_ack_i`.
- `adel_o`/`ades_o` out 1: load/store address-error flags. Combinational.
- `bus_err_o` out 1: bus-error or timeout pulse. Valid in DONE.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op: pass-through. `wd_o=wd_i`, `wreg_o=wreg_i`, `wdata_o=wdata_i`; HI/LO pass-through. `stall_req_o=0`.
- IDLE, misaligned op (halfword with `addr[0]`≠0; word/LL/SC with `addr[1:0]`≠0):
  - Raise `adel_o` for loads/LL, `ades_o` for stores/SC.
  - Force `wreg_o=0`. No bus access, no stall.
- IDLE, SC with LLbit=0: no bus access, no stall. `wreg_o=wreg_i`, `wdata_o=0`.
- IDLE, any other aligned memory op:
  - `stall_req_o=1`.
  - At the clock edge, load `bus_req_o=1`, `bus_we_o` (stores/SC), `bus_addr_o`, `bus_sel_o`, `bus_wdata_o`; go to WAIT.
- Lane index: `k = BIG_ENDIAN ? 3-addr[1:0] : addr[1:0]`. Lane k = bits 8k+7:8k.
- Store data: SB replicates the byte to all 4 lanes, `sel=1<<k`. SH replicates the halfword, `sel=0011` or `1100` per half. SW/SC use `sel=1111`.
- Load data: LB/LH sign-extend the selected lanes; LBU/LHU zero-extend; LW/LL pass all 32 bits.
- WAIT:
  - `stall_req_o=1`. Bus outputs held stable.
  - On `bus_ack_i` or `bus_err_i`: clear `bus_req_o`, latch rdata and error, go to DONE.
  - If `TIMEOUT>0` and the WAIT cycle counter reaches TIMEOUT-1 with no ack: same transition, latched as an error.
- DONE (one cycle), `stall_req_o=0`:
  - Loads: `wdata_o` = extracted data, `wreg_o=wreg_i`.
  - Stores: `wreg_o=0`.
  - SC: `wdata_o=1`, `wreg_o=wreg_i`.
  - Error, or flush seen during WAIT: `wreg_o=0`, `bus_err_o=1` (error case only).
  - Then go to IDLE.
- LLbit: set at the LL ack; cleared at the SC ack, on `flush_i`, and on `rst`.
- `flush_i` in WAIT: the bus transaction still completes (no abort). The result is discarded.

## Timing
- Reset: state IDLE, LLbit 0, counter 0, all bus outputs 0. While `rst=1`, every output is 0, including `wd_o`, `wdata_o`, `hi_o`, `lo_o`, `whilo_o`, `stall_req_o`, and the error flags.
- Non-memory ops, misaligned ops, and failed SC: 0 added latency, fully combinational.
- Memory ops occupy MEM for 2+N cycles (IDLE, WAIT×N, DONE), where N≥1 is the ack wait.
- Zero-wait slave (ack in the first WAIT cycle): 3 cycles, with 2 stall cycles.
- Upstream inputs stay frozen while `stall_req_o=1`. The new instruction appears in the cycle after DONE.
- `rst` mid-WAIT: IDLE next cycle and `bus_req_o=0`. The slave must tolerate a dropped request.
- `bus_ack_i` and `bus_err_i` in the same cycle: error wins.
- `bus_ack_i` on the cycle the timeout fires: ack wins.

## Test plan
- ALU pass-through: `wd_i=3`, `wreg_i=1`, `wdata_i=0x1234`, `mem_op_i=0` → same cycle `wd_o=3`, `wdata_o=0x1234`, `stall_req_o=0`.
- LB, big-endian: addr `0x101`, rdata `0x11807733`, ack after 2 WAIT cycles → `bus_addr_o=0x100`, `sel=0100`, `wdata_o=0xFFFFFF80`; `stall_req_o` high for 3 cycles.
- SH: addr `0x202`, `sdata=0xAAAA5678` → `bus_wdata_o=0x56785678`, `sel=0011`, `bus_we_o=1`, `wreg_o=0` in DONE.
- LL at `0x40`, then SC at `0x40` → SC stores with `wdata_o=1`. A second SC → no bus request, `wdata_o=0`. LL, flush, SC → `wdata_o=0`.
- LW at `0x3` → `adel_o=1`, `wreg_o=0`, `bus_req_o` stays 0, no stall.
- `TIMEOUT=4`, no ack → DONE after 4 WAIT cycles, `bus_err_o=1`, `wreg_o=0`. `rst` in WAIT → `bus_req_o=0` next cycle, all outputs 0.
